// File: rtl/ram_arbiter_if.sv
// Ram_if: single-port RAM access bundle shared by clients, arbiter and storage.
// An access completes in the cycle where en=1 and delay=0.
interface Ram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    en;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data_w;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    delay;

  // Storage-facing view: receives the request, answers with data and stall.
  modport memory (input en, addr, data_w, we, be, output data_r, delay);
  // Requester view: issues the request, receives data and stall.
  modport client (output en, addr, data_w, we, be, input data_r, delay);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM between two Ram_if clients.
// Forwarding is purely combinational; only the lock state, the last completed
// owner and the starvation counter are registered. The grant is held while the
// RAM stalls so a multi-cycle access is never interleaved with the other client.
module ram_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 0,
  parameter int MAX_WAIT    = 4
) (
  input  logic         clk,
  input  logic         reset,
  Ram_if.memory        c0,
  Ram_if.memory        c1,
  Ram_if.client        mem,
  output logic [1:0]   grant
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_SAT     = 8'd255;

  logic [1:0] state;
  logic       last;
  logic [7:0] wait_cnt;

  logic contested_pick;
  logic fwd;
  logic owner;
  logic done;

  // Winner when both clients request in IDLE.
  always_comb begin
    contested_pick = 1'b0;
    if (ROUND_ROBIN != 0) begin
      contested_pick = ~last;
    end else if (wait_cnt >= MAX_WAIT_CNT) begin
      contested_pick = 1'b1;
    end else begin
      contested_pick = 1'b0;
    end
  end

  // Owner of mem this cycle; a locked owner that drops en is not forwarded.
  always_comb begin
    fwd   = 1'b0;
    owner = 1'b0;
    case (state)
      IDLE: begin
        if (c0.en && c1.en) begin
          fwd   = 1'b1;
          owner = contested_pick;
        end else if (c0.en) begin
          fwd   = 1'b1;
          owner = 1'b0;
        end else if (c1.en) begin
          fwd   = 1'b1;
          owner = 1'b1;
        end else begin
          fwd   = 1'b0;
          owner = 1'b0;
        end
      end
      LOCK0: begin
        fwd   = c0.en;
        owner = 1'b0;
      end
      LOCK1: begin
        fwd   = c1.en;
        owner = 1'b1;
      end
      default: begin
        fwd   = 1'b0;
        owner = 1'b0;
      end
    endcase
  end

  assign done = fwd & ~mem.delay;

  // Route the owner to mem and stall the other client; reset forces a quiet bus.
  always_comb begin
    mem.en     = 1'b0;
    mem.addr   = '0;
    mem.data_w = '0;
    mem.we     = 1'b0;
    mem.be     = '0;
    grant      = 2'b00;
    c0.data_r  = '0;
    c1.data_r  = '0;
    c0.delay   = c0.en;
    c1.delay   = c1.en;
    if (!reset) begin
      c0.delay = 1'b1;
      c1.delay = 1'b1;
    end else if (fwd) begin
      if (owner) begin
        mem.en     = 1'b1;
        mem.addr   = c1.addr;
        mem.data_w = c1.data_w;
        mem.we     = c1.we;
        mem.be     = c1.be;
        grant      = 2'b10;
        c1.data_r  = mem.data_r;
        c1.delay   = mem.delay;
      end else begin
        mem.en     = 1'b1;
        mem.addr   = c0.addr;
        mem.data_w = c0.data_w;
        mem.we     = c0.we;
        mem.be     = c0.be;
        grant      = 2'b01;
        c0.data_r  = mem.data_r;
        c0.delay   = mem.delay;
      end
    end else begin
      grant = 2'b00;
    end
  end

  // Lock tracking and last completed owner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fwd && mem.delay) begin
            state <= owner ? LOCK1 : LOCK0;
          end else if (done) begin
            state <= IDLE;
            last  <= owner;
          end else begin
            state <= IDLE;
          end
        end
        LOCK0, LOCK1: begin
          if (!fwd) begin
            state <= IDLE;
          end else if (done) begin
            state <= IDLE;
            last  <= owner;
          end else begin
            state <= state;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Count client-0 completions that client 1 sat through.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
    end else if (ROUND_ROBIN != 0) begin
      wait_cnt <= 8'd0;
    end else if (!c1.en) begin
      wait_cnt <= 8'd0;
    end else if (done && owner) begin
      wait_cnt <= 8'd0;
    end else if (done && !owner && (wait_cnt != WAIT_SAT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

endmodule
